alu_arbiter: RTL and testbench

Two-port arbiter and sequencer that shares one `alu` instance between two requesters in `mips_core`, for example the execute stage and a multi-cycle helper unit. It accepts operand/opcode requests over valid/ready handshakes and grants them round-robin. It drives the ALU from registered operands for one cycle, captures the result and flags, and returns them to the granted requester over a valid/ready response channel. The ALU is instantiated outside this block; the block only drives its inputs and samples its outputs.

---
 rtl/alu_arbiter.sv | 132 +++++++++++++
 tb/tb_alu_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// alu_arbiter: round-robin two-port sequencer sharing one external ALU.
// Revision: 1.0
// ============================================================================
module alu_arbiter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [2:0]            req0_op,
    input  logic [DATA_WIDTH-1:0] req0_a,
    input  logic [DATA_WIDTH-1:0] req0_b,
    output logic                  rsp0_valid,
    input  logic                  rsp0_ready,
    output logic [DATA_WIDTH-1:0] rsp0_result,
    output logic [2:0]            rsp0_flags,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [2:0]            req1_op,
    input  logic [DATA_WIDTH-1:0] req1_a,
    input  logic [DATA_WIDTH-1:0] req1_b,
    output logic                  rsp1_valid,
    input  logic                  rsp1_ready,
    output logic [DATA_WIDTH-1:0] rsp1_result,
    output logic [2:0]            rsp1_flags,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [2:0]            alu_op,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_overflow,
    input  logic                  alu_carryout,
    input  logic                  alu_zero,
    output logic                  busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [2:0]            op_q, op_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [DATA_WIDTH-1:0] res_q, res_d;
    logic [2:0]            flg_q, flg_d;
    logic                  owner_q, owner_d;
    logic                  last_grant_q, last_grant_d;

    logic w_grant;
    logic w_accept;
    logic w_rsp_hs;

    // Under contention the requester that was not served last wins.
    assign w_grant    = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
    assign req0_ready = (state_q == S_IDLE) && !w_grant && req0_valid;
    assign req1_ready = (state_q == S_IDLE) &&  w_grant && req1_valid;
    assign w_accept   = req0_ready || req1_ready;

    assign rsp0_valid  = (state_q == S_RESP) && !owner_q;
    assign rsp1_valid  = (state_q == S_RESP) &&  owner_q;
    assign rsp0_result = res_q;
    assign rsp1_result = res_q;
    assign rsp0_flags  = flg_q;
    assign rsp1_flags  = flg_q;
    assign w_rsp_hs    = owner_q ? (rsp1_valid && rsp1_ready) : (rsp0_valid && rsp0_ready);

    assign alu_a  = a_q;
    assign alu_b  = b_q;
    assign alu_op = op_q;
    assign busy   = (state_q != S_IDLE);

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        res_d        = res_q;
        flg_d        = flg_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    op_d    = w_grant ? req1_op : req0_op;
                    a_d     = w_grant ? req1_a  : req0_a;
                    b_d     = w_grant ? req1_b  : req0_b;
                    owner_d = w_grant;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                res_d   = alu_result;
                flg_d   = {alu_overflow, alu_carryout, alu_zero};
                state_d = S_RESP;
            end
            S_RESP: begin
                if (w_rsp_hs) begin
                    last_grant_d = owner_q;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            op_q         <= 3'b000;
            a_q          <= '0;
            b_q          <= '0;
            res_q        <= '0;
            flg_q        <= 3'b000;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            res_q        <= res_d;
            flg_q        <= flg_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// Testbench for alu_arbiter: directed vectors, queue scoreboard, behavioural ALU.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [2:0]  req0_op = 3'b000, req1_op = 3'b000;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready = 1'b1, rsp1_ready = 1'b1;
    logic [31:0] rsp0_result, rsp1_result;
    logic [2:0]  rsp0_flags, rsp1_flags;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [2:0]  alu_op;
    logic        alu_overflow, alu_carryout, alu_zero;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          port;
        logic [31:0] res;
        logic [2:0]  flg;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_result(rsp0_result), .rsp0_flags(rsp0_flags),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_result(rsp1_result), .rsp1_flags(rsp1_flags),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_overflow(alu_overflow),
        .alu_carryout(alu_carryout), .alu_zero(alu_zero),
        .busy(busy)
    );

    // Behavioural MIPS-style ALU standing in for the external instance.
    logic [32:0] sum;
    always_comb begin
        sum          = '0;
        alu_result   = '0;
        alu_overflow = 1'b0;
        alu_carryout = 1'b0;
        case (alu_op)
            3'b000: alu_result = alu_a & alu_b;
            3'b001: alu_result = alu_a | alu_b;
            3'b010: begin
                sum          = {1'b0, alu_a} + {1'b0, alu_b};
                alu_result   = sum[31:0];
                alu_carryout = sum[32];
                alu_overflow = (alu_a[31] == alu_b[31]) && (sum[31] != alu_a[31]);
            end
            3'b110: begin
                sum          = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
                alu_result   = sum[31:0];
                alu_carryout = sum[32];
                alu_overflow = (alu_a[31] != alu_b[31]) && (sum[31] != alu_a[31]);
            end
            3'b111: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
            default: alu_result = alu_a ^ alu_b;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic expect_rsp(input int port, input logic [31:0] res, input logic [2:0] flg);
        exp_t e;
        e.port = port;
        e.res  = res;
        e.flg  = flg;
        exp_q.push_back(e);
    endtask

    task automatic score(input int port, input logic [31:0] res, input logic [2:0] flg);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_unexpected: port %0d result 0x%08h with empty scoreboard", port, res);
        end else begin
            e = exp_q.pop_front();
            chk("rsp_port", port, e.port);
            chk("rsp_result", res, e.res);
            chk("rsp_flags", {29'd0, flg}, {29'd0, e.flg});
        end
    endtask

    // Monitor: scores every response handshake and checks response exclusivity.
    always @(negedge clk) begin
        if (!rst) begin
            if (rsp0_valid && rsp1_valid) begin
                checks++;
                errors++;
                $display("FAIL rsp_onehot: both rsp valids high");
            end
            if (rsp0_valid && rsp0_ready) score(0, rsp0_result, rsp0_flags);
            if (rsp1_valid && rsp1_ready) score(1, rsp1_result, rsp1_flags);
        end
    end

    // Caller is aligned just after a rising edge; returns just after the accepting edge.
    task automatic send(input int port, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b);
        bit got = 1'b0;
        if (port == 0) begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = (port == 0) ? req0_ready : req1_ready;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: port %0d never got ready (got 0 expected 1)", port);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        chk("drain_pending", exp_q.size(), 0);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_req0_ready", req0_ready, 0);
        chk("rst_req1_ready", req1_ready, 0);
        chk("rst_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
        chk("rst_rsp0_result", rsp0_result, 0);
        chk("rst_rsp1_flags", rsp1_flags, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;

        // Contention right after reset: order 0,1,0,1 expected
        @(posedge clk); #1;
        expect_rsp(0, 32'h0000_0030, 3'b000);  // AND F0 & 3C
        expect_rsp(1, 32'h0000_00FF, 3'b000);  // OR  0F | F0
        expect_rsp(0, 32'd123,       3'b000);  // ADD 100 + 23
        expect_rsp(1, 32'd7,         3'b010);  // SUB 10 - 3, no borrow
        fork
            begin
                send(0, 3'b000, 32'hF0, 32'h3C);
                send(0, 3'b010, 32'd100, 32'd23);
                req0_valid = 1'b0;
            end
            begin
                send(1, 3'b001, 32'h0F, 32'hF0);
                send(1, 3'b110, 32'd10, 32'd3);
                req1_valid = 1'b0;
            end
        join
        wait_drain();

        // ADD with cycle-accurate timing
        @(posedge clk); #1;
        expect_rsp(0, 32'd12, 3'b000);
        req0_valid = 1'b1; req0_op = 3'b010; req0_a = 32'd5; req0_b = 32'd7;
        @(negedge clk);
        chk("add_ready_c0", req0_ready, 1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        chk("add_exec_busy", busy, 1);
        chk("add_exec_rsp0_valid", rsp0_valid, 0);
        chk("add_exec_alu_a", alu_a, 32'd5);
        chk("add_exec_alu_b", alu_b, 32'd7);
        chk("add_exec_alu_op", alu_op, 3'b010);
        @(negedge clk);
        chk("add_rsp_c2", rsp0_valid, 1);
        @(negedge clk);
        chk("add_idle_c3", busy, 0);

        // SUB to zero from requester 1
        @(posedge clk); #1;
        expect_rsp(1, 32'd0, 3'b011);
        send(1, 3'b110, 32'd3, 32'd3);
        req1_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("sub_rsp1_valid", rsp1_valid, 1);
        chk("sub_rsp0_quiet", rsp0_valid, 0);
        wait_drain();

        // ADD signed overflow, and an otherwise unused opcode forwarded unchanged
        @(posedge clk); #1;
        expect_rsp(0, 32'h8000_0000, 3'b100);
        send(0, 3'b010, 32'h7FFF_FFFF, 32'd1);
        req0_valid = 1'b0;
        wait_drain();
        @(posedge clk); #1;
        expect_rsp(1, 32'h0000_000A, 3'b000);
        send(1, 3'b101, 32'h0F, 32'h05);
        req1_valid = 1'b0;
        wait_drain();

        // Backpressure on requester 0 while requester 1 waits
        @(posedge clk); #1;
        rsp0_ready = 1'b0;
        expect_rsp(0, 32'd4, 3'b000);
        expect_rsp(1, 32'd3, 3'b000);
        send(0, 3'b010, 32'd2, 32'd2);
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_op = 3'b001; req1_a = 32'd1; req1_b = 32'd2;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_rsp0_valid", rsp0_valid, 1);
            chk("bp_result", rsp0_result, 32'd4);
            chk("bp_flags", rsp0_flags, 3'b000);
            chk("bp_req1_ready", req1_ready, 0);
            chk("bp_busy", busy, 1);
        end
        @(posedge clk); #1;
        rsp0_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_release_idle", busy, 0);
        chk("bp_release_req1_ready", req1_ready, 1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        wait_drain();

        // Reset during EXEC discards the operation
        @(posedge clk); #1;
        send(0, 3'b110, 32'd9, 32'd4);
        req0_valid = 1'b0;
        @(negedge clk);
        chk("mid_exec_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
        chk("mid_rst_alu_a", alu_a, 0);
        chk("mid_rst_alu_b", alu_b, 0);
        chk("mid_rst_alu_op", alu_op, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        expect_rsp(0, 32'd2, 3'b000);
        send(0, 3'b010, 32'd1, 32'd1);
        req0_valid = 1'b0;
        wait_drain();

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
